// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 32-bit ALU between two requesters, round-robin.
// Latency accept->rsp_valid: 2 cycles (add/sub/movi/other), MUL_CYCLES+1 (mul), DIV_CYCLES+1 (div).
// Backpressure: one op in flight; ready stays low until the response is taken, plus one idle bubble.
// Optional feature macro: ALU_ARB_DIVZERO_CHECK_EN (divide-by-zero short-circuit with rsp_err).
module alu_arbiter #(
    parameter int MUL_CYCLES = 2,   // EXEC cycles for opcode 4'b1000, 1..255
    parameter int DIV_CYCLES = 8    // EXEC cycles for opcode 4'b1001, 1..255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_alu_control,
    input  logic [31:0] req0_src1,
    input  logic [31:0] req0_src2,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_alu_control,
    input  logic [31:0] req1_src1,
    input  logic [31:0] req1_src2,

    output logic [3:0]  alu_control,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_err
);

    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic        last_grant_q;      // requester granted most recently
    logic [7:0]  cnt_q;             // EXEC cycles remaining, including the current one

    logic [3:0]  alu_control_q;
    logic [31:0] alu_src1_q;
    logic [31:0] alu_src2_q;

    logic        rsp_valid_q;
    logic        rsp_id_q;
    logic [31:0] rsp_result_q;
    logic        rsp_zero_q;
    logic        rsp_err_q;

    // Accept-side decode (combinational on the valids, only meaningful in IDLE)
    logic        gnt0_d;
    logic        gnt1_d;
    logic        accept_d;
    logic        acc_id_d;
    logic [3:0]  acc_ctl_d;
    logic [31:0] acc_src1_d;
    logic [31:0] acc_src2_d;
    logic [7:0]  cnt_d;
    logic        divzero_d;

    // Round-robin grant: a sole requester wins; on a tie the one not granted last time wins
    always_comb begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        if (state_q == S_IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt0_d = last_grant_q;
                gnt1_d = !last_grant_q;
            end else begin
                gnt0_d = req0_valid;
                gnt1_d = req1_valid;
            end
        end
    end

    assign req0_ready = gnt0_d;
    assign req1_ready = gnt1_d;
    assign accept_d   = gnt0_d | gnt1_d;
    assign acc_id_d   = gnt1_d;
    assign acc_ctl_d  = gnt1_d ? req1_alu_control : req0_alu_control;
    assign acc_src1_d = gnt1_d ? req1_src1 : req0_src1;
    assign acc_src2_d = gnt1_d ? req1_src2 : req0_src2;

    // Number of EXEC cycles to hold the ALU inputs for the accepted opcode
    always_comb begin
        cnt_d = 8'd1;
        case (acc_ctl_d)
            OP_MUL:  cnt_d = 8'(MUL_CYCLES);
            OP_DIV:  cnt_d = 8'(DIV_CYCLES);
            default: cnt_d = 8'd1;
        endcase
    end

`ifdef ALU_ARB_DIVZERO_CHECK_EN
    // Divide by zero is answered directly from IDLE without spending DIV_CYCLES
    assign divzero_d = (acc_ctl_d == OP_DIV) && (acc_src2_d == 32'd0);
`else
    // Feature disabled: divide by zero runs like any other divide, rsp_err never set
    assign divzero_d = 1'b0;
`endif

    // Control FSM with registered ALU operands and registered response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            last_grant_q  <= 1'b1;
            cnt_q         <= 8'd0;
            alu_control_q <= 4'd0;
            alu_src1_q    <= 32'd0;
            alu_src2_q    <= 32'd0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_result_q  <= 32'd0;
            rsp_zero_q    <= 1'b0;
            rsp_err_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        alu_control_q <= acc_ctl_d;
                        alu_src1_q    <= acc_src1_d;
                        alu_src2_q    <= acc_src2_d;
                        rsp_id_q      <= acc_id_d;
                        last_grant_q  <= acc_id_d;
                        cnt_q         <= cnt_d;
                        if (divzero_d) begin
                            rsp_result_q <= 32'hFFFF_FFFF;
                            rsp_zero_q   <= 1'b0;
                            rsp_err_q    <= 1'b1;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= S_RESP;
                        end else begin
                            state_q      <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    cnt_q <= cnt_q - 8'd1;
                    // <= rather than == so a zero count can never lock the FSM in EXEC
                    if (cnt_q <= 8'd1) begin
                        rsp_result_q <= alu_result;
                        rsp_zero_q   <= alu_zero;
                        rsp_err_q    <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign alu_control = alu_control_q;
    assign alu_src1    = alu_src1_q;
    assign alu_src2    = alu_src2_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed table, corner sequences and a randomized scoreboard run for alu_arbiter.
// Stimulus is driven at the falling edge; outputs are sampled 1 time unit after it.
// The ALU itself is modelled here as a plain arithmetic function.
module tb_alu_arbiter;

    localparam int MULC = 2;
    localparam int DIVC = 8;
`ifdef ALU_ARB_DIVZERO_CHECK_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_alu_control, req1_alu_control, alu_control;
    logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
    logic [31:0] alu_src1, alu_src2, alu_result, rsp_result;
    logic        alu_zero, rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_alu_control(req0_alu_control),
        .req0_src1(req0_src1), .req0_src2(req0_src2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_alu_control(req1_alu_control),
        .req1_src1(req1_src1), .req1_src2(req1_src2),
        .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b1000: return a * b;
            4'b1001: return (b == 32'd0) ? 32'hDEAD_BEEF : a / b;
            4'b0000: return b;
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        alu_result = ref_alu(alu_control, alu_src1, alu_src2);
        alu_zero   = (alu_result == 32'd0);
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    typedef struct {
        bit          id;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          zero;
        bit          err;
        int          lat;
        int          stall;
    } vec_t;

    // Expected response {id, zero, err, result}
    function automatic logic [34:0] ref_rsp(input bit id, input op_t o);
        logic [31:0] r;
        r = ref_alu(o.op, o.a, o.b);
        if (DZ && o.op == 4'b1001 && o.b == 32'd0) return {id, 1'b0, 1'b1, 32'hFFFF_FFFF};
        return {id, (r == 32'd0), 1'b0, r};
    endfunction

    function automatic int ref_lat(input op_t o);
        if (o.op == 4'b1000) return MULC + 1;
        if (o.op == 4'b1001) return (DZ && o.b == 32'd0) ? 1 : DIVC + 1;
        return 2;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int  k;
        k = $urandom_range(0, 9);
        case (k)
            0, 1:    o.op = 4'b0010;
            2, 3:    o.op = 4'b0110;
            4:       o.op = 4'b1000;
            5, 6:    o.op = 4'b1001;
            7:       o.op = 4'b0000;
            default: o.op = 4'($urandom_range(10, 15));
        endcase
        o.a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 50));
        o.b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 50));
        if (o.op == 4'b1001 && $urandom_range(0, 3) == 0) o.b = 32'd0;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called right after an accept was observed; waits for the response, checks it, takes it.
    task automatic expect_rsp(input string nm, input bit id, input logic [31:0] res, input bit zero,
                              input bit err, input int lat, input int stall);
        int n;
        n = 0;
        rsp_ready = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
            end
            #1;
        end while (!rsp_valid && n < 400);
        chk({nm, "_lat"}, 64'(n), 64'(lat));
        chk({nm, "_rsp"}, {rsp_id, rsp_zero, rsp_err, rsp_result}, {id, zero, err, res});
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            #1;
            chk({nm, "_hold"}, {rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_result}, {1'b1, id, zero, err, res});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk({nm, "_drop"}, 64'(rsp_valid), 64'd0);
    endtask

    vec_t tbl[9];
    op_t  q0[$];
    op_t  q1[$];

    initial begin
        bit          busy, free_next, have_exp, any_acc, v0, v1, g, seen;
        logic [34:0] exp_rsp;
        logic [67:0] held;
        int          due;
        op_t         o;

        tbl[0] = '{1'b0, 4'b0010, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 2, 0};
        tbl[1] = '{1'b1, 4'b0110, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 2, 0};
        tbl[2] = '{1'b0, 4'b1000, 32'd3, 32'd4, 32'd12, 1'b0, 1'b0, MULC + 1, 0};
        tbl[3] = '{1'b1, 4'b1001, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, DIVC + 1, 5};
        tbl[4] = '{1'b0, 4'b0000, 32'd1, 32'h1234, 32'h1234, 1'b0, 1'b0, 2, 0};
        tbl[5] = '{1'b1, 4'b1111, 32'd5, 32'd6, 32'd0, 1'b1, 1'b0, 2, 0};
        tbl[6] = '{1'b0, 4'b0110, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 2, 2};
        tbl[7] = '{1'b1, 4'b1000, 32'h10000, 32'h10000, 32'd0, 1'b1, 1'b0, MULC + 1, 0};
`ifdef ALU_ARB_DIVZERO_CHECK_EN
        tbl[8] = '{1'b0, 4'b1001, 32'd8, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1, 0};
`else
        tbl[8] = '{1'b0, 4'b1001, 32'd8, 32'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, DIVC + 1, 0};
`endif

        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_alu_control = 4'd0; req0_src1 = 32'd0; req0_src2 = 32'd0;
        req1_valid = 1'b0; req1_alu_control = 4'd0; req1_src1 = 32'd0; req1_src2 = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_rsp", {rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_result}, 64'd0);
        chk("reset_alu", {req1_ready, req0_ready, alu_control, alu_src1, alu_src2}, 64'd0);
        rst_n = 1'b1;

        // Directed table: one requester at a time
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (tbl[i].id) begin
                req1_valid = 1'b1; req1_alu_control = tbl[i].op; req1_src1 = tbl[i].a; req1_src2 = tbl[i].b;
            end else begin
                req0_valid = 1'b1; req0_alu_control = tbl[i].op; req0_src1 = tbl[i].a; req0_src2 = tbl[i].b;
            end
            #1;
            chk($sformatf("tbl%0d_grant", i), {req1_ready, req0_ready}, tbl[i].id ? 2'b10 : 2'b01);
            expect_rsp($sformatf("tbl%0d", i), tbl[i].id, tbl[i].res, tbl[i].zero, tbl[i].err,
                       tbl[i].lat, tbl[i].stall);
        end

        // Simultaneous requests after reset: req0 first, req1 next
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_alu_control = 4'b0110; req0_src1 = 32'd9; req0_src2 = 32'd9;
        req1_valid = 1'b1; req1_alu_control = 4'b1000; req1_src1 = 32'd3; req1_src2 = 32'd4;
        #1;
        chk("tie_grant0", {req1_ready, req0_ready}, 2'b01);
        expect_rsp("tie_first", 1'b0, 32'd0, 1'b1, 1'b0, 2, 0);
        chk("tie_grant1", {req1_ready, req0_ready}, 2'b10);
        expect_rsp("tie_second", 1'b1, 32'd12, 1'b0, 1'b0, MULC + 1, 0);

        // Both continuously valid: grants alternate 0,1,0,1,0,1
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_alu_control = 4'b0010; req0_src1 = 32'd1;  req0_src2 = 32'd2;
        req1_valid = 1'b1; req1_alu_control = 4'b0010; req1_src1 = 32'd10; req1_src2 = 32'd20;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("alt%0d_grant", k), {req1_ready, req0_ready}, (k % 2) ? 2'b10 : 2'b01);
            expect_rsp($sformatf("alt%0d", k), (k % 2) == 1, (k % 2) ? 32'd30 : 32'd3, 1'b0, 1'b0, 2, 0);
            if (k % 2) req1_valid = 1'b1; else req0_valid = 1'b1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Reset in the middle of a req0 divide: operation discarded, req0 wins the next tie
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_alu_control = 4'b1001; req0_src1 = 32'd100; req0_src2 = 32'd7;
        #1;
        chk("rst_exec_grant", {req1_ready, req0_ready}, 2'b01);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_exec_clear", {rsp_valid, alu_control, alu_src1, alu_src2}, 64'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            seen = seen | rsp_valid;
        end
        chk("rst_exec_discard", 64'(seen), 64'd0);
        req0_valid = 1'b1; req0_alu_control = 4'b0010; req0_src1 = 32'd2; req0_src2 = 32'd2;
        req1_valid = 1'b1; req1_alu_control = 4'b0110; req1_src1 = 32'd5; req1_src2 = 32'd1;
        #1;
        chk("rst_exec_tie", {req1_ready, req0_ready}, 2'b01);
        expect_rsp("rst_exec_r0", 1'b0, 32'd4, 1'b0, 1'b0, 2, 0);
        chk("rst_exec_next", {req1_ready, req0_ready}, 2'b10);
        expect_rsp("rst_exec_r1", 1'b1, 32'd4, 1'b0, 1'b0, 2, 0);

        // Reset while a response is stalled in RESP
        @(negedge clk);
        req1_valid = 1'b1; req1_alu_control = 4'b0010; req1_src1 = 32'd1; req1_src2 = 32'd1;
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_resp_pending", {rsp_valid, rsp_result}, {1'b1, 32'd2});
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_resp_clear", {rsp_valid, rsp_id, rsp_result}, 64'd0);
        rst_n = 1'b1;

        // Randomized traffic against the transaction-level scoreboard
        do_reset();
        busy = 1'b0; free_next = 1'b0; have_exp = 1'b0; any_acc = 1'b0; g = 1'b0;
        exp_rsp = '0; held = '0; due = 0;
        begin
            bit mdl_last;
            mdl_last = 1'b1;
            for (int cyc = 0; cyc < 1500; cyc++) begin
                @(negedge clk);
                if (free_next) begin busy = 1'b0; free_next = 1'b0; end
                if (q0.size() < 3 && $urandom_range(0, 2) == 0) q0.push_back(rand_op());
                if (q1.size() < 3 && $urandom_range(0, 2) == 0) q1.push_back(rand_op());
                v0 = (q0.size() > 0) && ($urandom_range(0, 9) != 0);
                v1 = (q1.size() > 0) && ($urandom_range(0, 9) != 0);
                req0_valid = v0;
                if (v0) begin req0_alu_control = q0[0].op; req0_src1 = q0[0].a; req0_src2 = q0[0].b; end
                else begin req0_alu_control = 4'($urandom); req0_src1 = $urandom; req0_src2 = $urandom; end
                req1_valid = v1;
                if (v1) begin req1_alu_control = q1[0].op; req1_src1 = q1[0].a; req1_src2 = q1[0].b; end
                else begin req1_alu_control = 4'($urandom); req1_src1 = $urandom; req1_src2 = $urandom; end
                rsp_ready = ($urandom_range(0, 3) != 0);
                #1;
                if (have_exp) begin
                    if (cyc < due) chk("rnd_early", 64'(rsp_valid), 64'd0);
                    else begin
                        chk("rnd_rsp", {rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_result}, {1'b1, exp_rsp});
                        if (rsp_valid && rsp_ready) begin have_exp = 1'b0; free_next = 1'b1; end
                    end
                end else begin
                    chk("rnd_idle_rsp", 64'(rsp_valid), 64'd0);
                end
                if (any_acc) chk("rnd_alu_hold", {alu_control, alu_src1, alu_src2}, held);
                if (!busy && (v0 || v1)) begin
                    g = (v0 && v1) ? !mdl_last : v1;
                    chk("rnd_grant", {req1_ready, req0_ready}, g ? 2'b10 : 2'b01);
                    o = g ? q1.pop_front() : q0.pop_front();
                    held = {o.op, o.a, o.b};
                    any_acc = 1'b1;
                    mdl_last = g;
                    busy = 1'b1;
                    exp_rsp = ref_rsp(g, o);
                    due = cyc + ref_lat(o);
                    have_exp = 1'b1;
                end else begin
                    chk("rnd_no_grant", {req1_ready, req0_ready}, 2'b00);
                end
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

endmodule
